// File: rtl/fptd_pkg.sv
// fptd_pkg: shared constants for the 8-state max-log-MAP decoder core.
//   NUM_STATES   trellis state count
//   METRIC_W     default width of one stored state metric
//   metric_t     signed state metric of default width
//   ST_*         forward-recursion FSM state encodings
//   ALPHA_INIT   metric assigned to states 1..7 when a first window starts
//   idx_width()  width of a step index for a window of given depth (min 1 bit)
package fptd_pkg;

    localparam int NUM_STATES = 8;
    localparam int METRIC_W   = 6;

    typedef logic signed [METRIC_W-1:0] metric_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FWD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Most negative metric: every state except 0 starts "impossible".
    localparam metric_t ALPHA_INIT = {1'b1, {(METRIC_W-1){1'b0}}};

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/alpha_recursion_lifo_if.sv
// alpha_recursion_lifo_if: handshake bundle of the alpha recursion block.
//   start/first_win              window control (master -> block)
//   gam_valid/gam_ready, ba*     branch-metric triple stream into the block
//   alpha_valid/alpha_ready      reversed alpha stream towards the LLR stage
//   alpha_out/alpha_idx          alpha_k[7:1] (state s at bits (s-1)*M) and k
//   done                         one-cycle pulse after the last drain beat
//   Error_current_Alpha          razor timing-error flag
// modport master: LLR/control side; modport slave: the alpha block.
interface alpha_recursion_lifo_if #(
    parameter int N = 5,
    parameter int M = 6,
    parameter int W = 8
);
    localparam int KW = (W > 1) ? $clog2(W) : 1;

    logic                  start;
    logic                  first_win;
    logic                  gam_valid;
    logic                  gam_ready;
    logic signed [N-1:0]   ba2;
    logic signed [M:0]     ba1ba3;
    logic signed [M:0]     ba1ba2ba3;
    logic                  alpha_valid;
    logic                  alpha_ready;
    logic [7*M-1:0]        alpha_out;
    logic [KW-1:0]         alpha_idx;
    logic                  done;
    logic                  Error_current_Alpha;

    modport master (
        output start, first_win, gam_valid, ba2, ba1ba3, ba1ba2ba3, alpha_ready,
        input  gam_ready, alpha_valid, alpha_out, alpha_idx, done, Error_current_Alpha
    );

    modport slave (
        input  start, first_win, gam_valid, ba2, ba1ba3, ba1ba2ba3, alpha_ready,
        output gam_ready, alpha_valid, alpha_out, alpha_idx, done, Error_current_Alpha
    );

endinterface

// File: rtl/BitClip.sv
// BitClip: saturate a signed value to a narrower signed width.
//   din   in   IN_W   signed input
//   dout  out  OUT_W  din clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module BitClip #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 6
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    logic fits;

    // Value fits when all bits above the output sign bit replicate the sign.
    assign fits = (din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){din[IN_W-1]}});

    always_comb begin
        dout = din[OUT_W-1:0];
        if (!fits) begin
            if (din[IN_W-1]) dout = {1'b1, {(OUT_W-1){1'b0}}};
            else             dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/alpha_acs.sv
// alpha_acs: combinational add-compare-select for one forward trellis step,
// followed by normalisation against state 0 and saturation.
//   alpha_in    in   7xM   alpha_k[7:1] (alpha_k[0] is 0 by construction)
//   g2          in   N     ba2
//   g13         in   M+1   ba1ba3
//   g123        in   M+1   ba1ba2ba3
//   alpha_next  out  7xM   alpha_{k+1}[7:1]
module alpha_acs
    import fptd_pkg::*;
#(
    parameter int N = 5,
    parameter int M = 6
) (
    input  logic [NUM_STATES-2:0][M-1:0] alpha_in,
    input  logic signed [N-1:0]          g2,
    input  logic signed [M:0]            g13,
    input  logic signed [M:0]            g123,
    output logic [NUM_STATES-2:0][M-1:0] alpha_next
);

    localparam int SW = M + 2;
    localparam int DW = M + 3;

    logic signed [SW-1:0] a [NUM_STATES];
    logic signed [SW-1:0] n [NUM_STATES];
    logic signed [SW-1:0] e2, e13, e123;
    logic signed [DW-1:0] d [1:NUM_STATES-1];
    logic signed [M-1:0]  clip [1:NUM_STATES-1];

    // Ties resolve to the first operand.
    function automatic logic signed [SW-1:0] max2(input logic signed [SW-1:0] x,
                                                  input logic signed [SW-1:0] y);
        return (x >= y) ? x : y;
    endfunction

    always_comb begin
        e2   = {{(SW-N){g2[N-1]}}, g2};
        e13  = {g13[M], g13};
        e123 = {g123[M], g123};
        a[0] = '0;
        for (int s = 1; s < NUM_STATES; s++) begin
            a[s] = {{2{alpha_in[s-1][M-1]}}, alpha_in[s-1]};
        end
        n[0] = max2(a[0],        a[1] + e123);
        n[1] = max2(a[2] + e13,  a[3] + e2);
        n[2] = max2(a[4] + e2,   a[5] + e13);
        n[3] = max2(a[6] + e123, a[7]);
        n[4] = max2(a[0] + e123, a[1]);
        n[5] = max2(a[2] + e2,   a[3] + e13);
        n[6] = max2(a[4] + e13,  a[5] + e2);
        n[7] = max2(a[6],        a[7] + e123);
        for (int s = 1; s < NUM_STATES; s++) begin
            d[s] = {n[s][SW-1], n[s]} - {n[0][SW-1], n[0]};
        end
    end

    for (genvar s = 1; s < NUM_STATES; s++) begin : g_clip
        BitClip #(.IN_W(DW), .OUT_W(M)) u_clip (
            .din  (d[s]),
            .dout (clip[s])
        );
    end

    always_comb begin
        for (int s = 1; s < NUM_STATES; s++) begin
            alpha_next[s-1] = clip[s];
        end
    end

endmodule

// File: rtl/alpha_recursion_lifo.sv
// alpha_recursion_lifo: forward (alpha) state-metric recursion with a LIFO
// that replays the window's alphas in reverse order to the LLR stage.
//   Clock    in   rising-edge clock
//   nReset   in   asynchronous active-low reset
//   bus      slave side of alpha_recursion_lifo_if (gamma in, alpha out)
// Build option: ALPHA_RAZOR_EN adds a high-phase shadow latch on bit
// [M-RazorBit] of each next-alpha and drives Error_current_Alpha from it;
// without it Error_current_Alpha is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; alpha register holds carry metric
// ST_FWD   | one ACS step per gamma handshake, alpha_k pushed to LIFO[k]
// ST_DRAIN | LIFO replayed k = W-1 .. 0 with valid/ready handshake
module alpha_recursion_lifo
    import fptd_pkg::*;
#(
    parameter int N        = 5,
    parameter int M        = 6,
    parameter int W        = 8,
    parameter int RazorBit = 1
) (
    input  logic                  Clock,
    input  logic                  nReset,
    alpha_recursion_lifo_if.slave bus
);

    localparam int KW = idx_width(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef logic [NUM_STATES-2:0][M-1:0] avec_t;

    localparam avec_t INIT_VEC = {(NUM_STATES-1){{1'b1, {(M-1){1'b0}}}}};

    logic [1:0]          state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    avec_t               alpha_q, alpha_d;
    logic                done_q, done_d;
    logic [W-1:0][NUM_STATES-2:0][M-1:0] lifo_q, lifo_d;
    avec_t               alpha_next;

    alpha_acs #(.N(N), .M(M)) u_acs (
        .alpha_in   (alpha_q),
        .g2         (bus.ba2),
        .g13        (bus.ba1ba3),
        .g123       (bus.ba1ba2ba3),
        .alpha_next (alpha_next)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        alpha_d = alpha_q;
        done_d  = 1'b0;
        lifo_d  = lifo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FWD;
                    k_d     = '0;
                    if (bus.first_win) alpha_d = INIT_VEC;
                end
            end
            ST_FWD: begin
                if (bus.gam_valid) begin
                    lifo_d[k_q] = alpha_q;
                    alpha_d     = alpha_next;
                    // k is left at W-1 so the drain starts from the newest entry.
                    if (k_q == K_LAST) state_d = ST_DRAIN;
                    else               k_d     = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.alpha_ready) begin
                    if (k_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            alpha_q <= INIT_VEC;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            alpha_q <= alpha_d;
            done_q  <= done_d;
        end
    end

    // Storage only; contents are meaningless until written in FWD.
    always_ff @(posedge Clock) begin
        lifo_q <= lifo_d;
    end

    assign bus.gam_ready   = (state_q == ST_FWD);
    assign bus.alpha_valid = (state_q == ST_DRAIN);
    assign bus.alpha_out   = (state_q == ST_DRAIN) ? lifo_q[k_q] : '0;
    assign bus.alpha_idx   = (state_q == ST_DRAIN) ? k_q : '0;
    assign bus.done        = done_q;

`ifdef ALPHA_RAZOR_EN
    localparam int RZ = M - RazorBit;

    logic [NUM_STATES-2:0] razor_now;
    logic [NUM_STATES-2:0] razor_reg;
    logic [NUM_STATES-2:0] razor_lat;

    always_comb begin
        for (int s = 0; s < NUM_STATES - 1; s++) begin
            razor_now[s] = alpha_next[s][RZ];
            razor_reg[s] = alpha_q[s][RZ];
        end
    end

    // Shadow latch open during the high phase: a late-settling next-alpha
    // bit differs from what the flop captured at the rising edge.
    always_latch begin
        if (!nReset)    razor_lat <= '0;
        else if (Clock) razor_lat <= razor_now;
    end

    assign bus.Error_current_Alpha = |(razor_lat ^ razor_reg);
`else
    assign bus.Error_current_Alpha = 1'b0;
`endif

endmodule

// File: tb/tb_alpha_recursion_lifo.sv
module tb_alpha_recursion_lifo;

    localparam int N  = 5;
    localparam int M  = 6;
    localparam int W  = 4;
    localparam int VW = 7 * M;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;

    alpha_recursion_lifo_if #(.N(N), .M(M), .W(W)) bus ();

    alpha_recursion_lifo #(.N(N), .M(M), .W(W), .RazorBit(1)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference: alpha metrics of the eight trellis states as plain integers.
    int model_a [8];
    int exp_idx [$];
    logic [VW-1:0] exp_vec [$];

    bit rdy_random = 1'b1;
    int stall_idx  = -1;
    int stall_left = 0;
    int done_cnt   = 0;

    bit            exp_done   = 1'b0;
    bit            prev_stall = 1'b0;
    logic [VW-1:0] prev_vec;
    int            prev_idx;

    task automatic model_init();
        model_a[0] = 0;
        for (int s = 1; s < 8; s++) model_a[s] = -(1 << (M - 1));
    endtask

    function automatic logic [VW-1:0] pack_model();
        logic [VW-1:0] v;
        v = '0;
        for (int s = 1; s < 8; s++) v[(s-1)*M +: M] = M'(model_a[s]);
        return v;
    endfunction

    // Trellis: next state ns takes max over (pred0 + label0, pred1 + label1);
    // label 0 = no metric, 1 = ba2, 2 = ba1ba3, 3 = ba1ba2ba3.
    task automatic model_step(input int g2, input int g13, input int g123);
        int p0 [8] = '{0, 2, 4, 6, 0, 2, 4, 6};
        int l0 [8] = '{0, 2, 1, 3, 3, 1, 2, 0};
        int p1 [8] = '{1, 3, 5, 7, 1, 3, 5, 7};
        int l1 [8] = '{3, 1, 2, 0, 0, 2, 1, 3};
        int gv [4];
        int n  [8];
        int x, y, dd;
        int lo, hi;
        gv[0] = 0; gv[1] = g2; gv[2] = g13; gv[3] = g123;
        lo = -(1 << (M - 1));
        hi = (1 << (M - 1)) - 1;
        for (int s = 0; s < 8; s++) begin
            x = model_a[p0[s]] + gv[l0[s]];
            y = model_a[p1[s]] + gv[l1[s]];
            n[s] = (x >= y) ? x : y;
        end
        for (int s = 0; s < 8; s++) begin
            dd = n[s] - n[0];
            if (dd > hi) dd = hi;
            if (dd < lo) dd = lo;
            model_a[s] = dd;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge Clock) begin
        int ei;
        logic [VW-1:0] ev;
        if (!nReset) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (bus.done !== exp_done) begin
                errors++;
                $display("FAIL done: got %b want %b", bus.done, exp_done);
            end
            if (bus.done === 1'b1) done_cnt++;
`ifndef ALPHA_RAZOR_EN
            checks++;
            if (bus.Error_current_Alpha !== 1'b0) begin
                errors++;
                $display("FAIL razor_flag: got %b want 0", bus.Error_current_Alpha);
            end
`endif
            exp_done = 1'b0;
            if (bus.alpha_valid === 1'b1) begin
                if (prev_stall) begin
                    checks++;
                    if (bus.alpha_out !== prev_vec || int'(bus.alpha_idx) != prev_idx) begin
                        errors++;
                        $display("FAIL stall_hold: got idx %0d alpha %h want idx %0d alpha %h",
                                 bus.alpha_idx, bus.alpha_out, prev_idx, prev_vec);
                    end
                end
                if (bus.alpha_ready === 1'b1) begin
                    checks++;
                    if (exp_idx.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got idx %0d alpha %h want no beat",
                                 bus.alpha_idx, bus.alpha_out);
                    end else begin
                        ei = exp_idx.pop_front();
                        ev = exp_vec.pop_front();
                        if (int'(bus.alpha_idx) != ei || bus.alpha_out !== ev) begin
                            errors++;
                            $display("FAIL beat: got idx %0d alpha %h want idx %0d alpha %h",
                                     bus.alpha_idx, bus.alpha_out, ei, ev);
                        end
                        if (ei == 0) exp_done = 1'b1;
                    end
                end
            end
            prev_stall = (bus.alpha_valid === 1'b1) && (bus.alpha_ready !== 1'b1);
            prev_vec   = bus.alpha_out;
            prev_idx   = int'(bus.alpha_idx);
        end
    end

    // LLR-side ready driver
    always @(posedge Clock) begin
        #1;
        if (stall_left > 0 && bus.alpha_valid === 1'b1 && int'(bus.alpha_idx) == stall_idx) begin
            bus.alpha_ready = 1'b0;
            stall_left--;
        end else if (rdy_random) begin
            bus.alpha_ready = ($urandom_range(0, 3) != 0);
        end else begin
            bus.alpha_ready = 1'b1;
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // mode 0: random gammas with bubbles; 1: all zero; 2: step0 ba1ba2ba3=+63 then random
    task automatic run_window(input bit fw, input int mode, input bit poke_start);
        int g2, g13, g123;
        bus.start     = 1'b1;
        bus.first_win = fw;
        @(posedge Clock); #1;
        bus.start     = 1'b0;
        bus.first_win = 1'b0;
        if (fw) model_init();
        for (int k = 0; k < W; k++) begin
            if (mode == 0 && $urandom_range(0, 2) == 0) begin
                bus.gam_valid = 1'b0;
                @(posedge Clock); #1;
            end
            if (mode == 1) begin
                g2 = 0; g13 = 0; g123 = 0;
            end else if (mode == 2 && k == 0) begin
                g2 = 0; g13 = 0; g123 = 63;
            end else begin
                g2   = $urandom_range(0, 31) - 16;
                g13  = $urandom_range(0, 127) - 64;
                g123 = $urandom_range(0, 127) - 64;
            end
            bus.gam_valid = 1'b1;
            bus.ba2       = N'(g2);
            bus.ba1ba3    = (M+1)'(g13);
            bus.ba1ba2ba3 = (M+1)'(g123);
            if (poke_start && k == 1) begin
                bus.start     = 1'b1;
                bus.first_win = 1'b1;
            end
            @(negedge Clock);
            check_bit("gam_ready_fwd", bus.gam_ready, 1'b1);
            exp_idx.push_front(k);
            exp_vec.push_front(pack_model());
            model_step(g2, g13, g123);
            @(posedge Clock); #1;
            bus.start     = 1'b0;
            bus.first_win = 1'b0;
        end
        bus.gam_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        while ((exp_idx.size() != 0 || done_cnt == d0) && t < 200) begin
            @(posedge Clock); #1;
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats left, done_seen %0d want 0 left, done 1",
                     exp_idx.size(), done_cnt - d0);
            exp_idx.delete();
            exp_vec.delete();
        end
        @(posedge Clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.first_win   = 1'b0;
        bus.gam_valid   = 1'b0;
        bus.ba2         = '0;
        bus.ba1ba3      = '0;
        bus.ba1ba2ba3   = '0;
        bus.alpha_ready = 1'b1;
        model_init();

        nReset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check_bit("rst_gam_ready", bus.gam_ready, 1'b0);
        check_bit("rst_alpha_valid", bus.alpha_valid, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);
`ifndef ALPHA_RAZOR_EN
        check_bit("rst_razor", bus.Error_current_Alpha, 1'b0);
`endif
        checks++;
        if (bus.alpha_out !== '0 || bus.alpha_idx !== '0) begin
            errors++;
            $display("FAIL rst_alpha_out: got %h/%0d want 0/0", bus.alpha_out, bus.alpha_idx);
        end
        @(posedge Clock); #3;
        nReset = 1'b1;
        @(posedge Clock); #1;

        // zero gammas from the first-window init pattern
        run_window(1'b1, 1, 1'b0);
        wait_drain();

        // saturating step plus a three-cycle stall at idx 2
        rdy_random = 1'b0;
        stall_idx  = 2;
        stall_left = 3;
        run_window(1'b1, 2, 1'b0);
        wait_drain();
        rdy_random = 1'b1;
        stall_left = 0;

        // carried alpha, start poked mid-window
        run_window(1'b0, 0, 1'b1);
        wait_drain();

        for (int i = 0; i < 8; i++) begin
            run_window(1'($urandom_range(0, 1)), 0, 1'b0);
            wait_drain();
        end

        // reset in the middle of a forward pass discards the window
        bus.start     = 1'b1;
        bus.first_win = 1'b1;
        @(posedge Clock); #1;
        bus.start     = 1'b0;
        bus.first_win = 1'b0;
        bus.gam_valid = 1'b1;
        bus.ba2       = N'(5);
        bus.ba1ba3    = (M+1)'(-20);
        bus.ba1ba2ba3 = (M+1)'(40);
        repeat (2) @(posedge Clock);
        #1;
        nReset = 1'b0;
        #2;
        check_bit("midrst_gam_ready", bus.gam_ready, 1'b0);
        check_bit("midrst_alpha_valid", bus.alpha_valid, 1'b0);
        check_bit("midrst_done", bus.done, 1'b0);
        bus.gam_valid = 1'b0;
        exp_idx.delete();
        exp_vec.delete();
        model_init();
        @(posedge Clock); #3;
        nReset = 1'b1;
        @(posedge Clock); #1;
        check_bit("post_rst_idle", bus.gam_ready, 1'b0);

        // carry after reset continues from the init pattern
        run_window(1'b0, 0, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
